// File: rtl/audio_capture_pkg.sv
`default_nettype none
// ============================================================================
// audio_capture_pkg : state type and channel/byte-enable constants
// Revision: 1.0
// ============================================================================
package audio_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam logic [1:0] CH_LEFT        = 2'd0;
  localparam logic [1:0] CH_RIGHT       = 2'd1;
  localparam logic [7:0] BYTEENABLE_ALL = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/audio_capture_writer_stereo_word_packer.sv
`default_nettype none
// ============================================================================
// stereo_word_packer : pairs a held left sample with the next right sample
// Revision: 1.0
// ============================================================================
module stereo_word_packer
  import audio_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      armed,
  input  logic                      sample_valid,
  input  logic [1:0]                sample_channel,
  input  logic [SAMPLE_WIDTH-1:0]   sample_data,
  output logic                      pair_valid,
  output logic [2*SAMPLE_WIDTH-1:0] pair_word,
  output logic                      sync_error
);

  logic [SAMPLE_WIDTH-1:0] r_left;
  logic                    r_held;
  logic                    w_take_left;
  logic                    w_take_right;

  // While armed, right samples are not yet meaningful and are dropped quietly.
  assign w_take_left  = enable && sample_valid && (sample_channel == CH_LEFT);
  assign w_take_right = enable && !armed && sample_valid && (sample_channel == CH_RIGHT);

  assign pair_valid = w_take_right && r_held;
  assign pair_word  = {sample_data, r_left};
  assign sync_error = (w_take_left && r_held) || (w_take_right && !r_held);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_left <= '0;
      r_held <= 1'b0;
    end else if (clear) begin
      r_held <= 1'b0;
    end else if (w_take_left) begin
      r_left <= sample_data;
      r_held <= 1'b1;
    end else if (pair_valid) begin
      r_held <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_capture_writer.sv
`default_nettype none
// ============================================================================
// audio_capture_writer : packs stereo Avalon-ST audio into 64-bit memory writes
// Revision: 1.0
// ============================================================================
module audio_capture_writer
  import audio_capture_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DEPTH        = 8192,
  parameter int SAMPLE_WIDTH = 32,
  parameter int CIRCULAR     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_WIDTH-1:0]   avalon_sink_data,
  input  logic [1:0]                avalon_sink_channel,
  input  logic                      avalon_sink_valid,
  input  logic                      start,
  input  logic                      stop,
  input  logic [ADDR_WIDTH:0]       capture_words,
  output logic [ADDR_WIDTH-1:0]     address,
  output logic [7:0]                byteenable,
  output logic                      chipselect,
  output logic                      write,
  output logic [2*SAMPLE_WIDTH-1:0] writedata,
  output logic                      clken,
  output logic                      busy,
  output logic                      done,
  output logic                      wrapped,
  output logic                      sync_err,
  output logic [ADDR_WIDTH:0]       words_written
);

  localparam logic [ADDR_WIDTH:0]   c_depth_words = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr   = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    c_circular    = (CIRCULAR != 0);

  capture_state_t r_state;
  capture_state_t w_next_state;

  logic [ADDR_WIDTH-1:0]     r_pointer;
  logic [ADDR_WIDTH:0]       r_words;
  logic [ADDR_WIDTH:0]       r_target;
  logic                      r_write;
  logic [2*SAMPLE_WIDTH-1:0] r_writedata;
  logic                      r_done;
  logic                      r_wrapped;
  logic                      r_sync_err;

  logic                      w_busy;
  logic                      w_start_accept;
  logic                      w_stop_accept;
  logic                      w_final_write;
  logic [ADDR_WIDTH:0]       w_words_inc;
  logic                      w_pack_enable;
  logic                      w_pack_clear;
  logic                      w_pair_valid;
  logic [2*SAMPLE_WIDTH-1:0] w_pair_word;
  logic                      w_sync_error;

  assign w_busy         = (r_state == ARMED) || (r_state == CAPTURE);
  assign w_start_accept = start && !w_busy;
  assign w_stop_accept  = stop && w_busy;
  assign w_words_inc    = r_words + (ADDR_WIDTH+1)'(1);

  // The cycle that writes the last one-shot word already belongs to the
  // finished capture: samples arriving in it are ignored.
  assign w_final_write  = !c_circular && r_write && (r_state == CAPTURE) &&
                          (w_words_inc == r_target);
  assign w_pack_enable  = w_busy && !w_final_write;
  assign w_pack_clear   = w_stop_accept || w_start_accept;

  stereo_word_packer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_packer (
    .clk            (clk),
    .reset          (reset),
    .clear          (w_pack_clear),
    .enable         (w_pack_enable),
    .armed          (r_state == ARMED),
    .sample_valid   (avalon_sink_valid),
    .sample_channel (avalon_sink_channel),
    .sample_data    (avalon_sink_data),
    .pair_valid     (w_pair_valid),
    .pair_word      (w_pair_word),
    .sync_error     (w_sync_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          w_next_state = DONE;
        end else if (avalon_sink_valid && (avalon_sink_channel == CH_LEFT)) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop || w_final_write) begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pointer   <= '0;
      r_words     <= '0;
      r_target    <= '0;
      r_write     <= 1'b0;
      r_writedata <= '0;
      r_done      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_write <= w_pair_valid;
      if (w_pair_valid) begin
        r_writedata <= w_pair_word;
      end

      if (w_start_accept) begin
        r_pointer  <= '0;
        r_words    <= '0;
        r_done     <= 1'b0;
        r_wrapped  <= 1'b0;
        r_sync_err <= 1'b0;
        r_target   <= (capture_words == '0) ? c_depth_words : capture_words;
      end else begin
        if (r_write) begin
          r_pointer <= r_pointer + ADDR_WIDTH'(1);
          if (c_circular && (r_pointer == c_last_addr)) begin
            r_wrapped <= 1'b1;
          end
          // Continuous capture saturates the count once memory is full.
          if (!c_circular || (r_words != c_depth_words)) begin
            r_words <= w_words_inc;
          end
        end
        if (w_sync_error) begin
          r_sync_err <= 1'b1;
        end
        if (w_busy && (w_next_state == DONE)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign address       = r_pointer;
  assign byteenable    = BYTEENABLE_ALL;
  assign chipselect    = r_write;
  assign write         = r_write;
  assign writedata     = r_writedata;
  assign clken         = 1'b1;
  assign busy          = w_busy;
  assign done          = r_done;
  assign wrapped       = r_wrapped;
  assign sync_err      = r_sync_err;
  assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_audio_capture_writer.sv
`default_nettype none
// ============================================================================
// tb_audio_capture_writer : directed + random bench with a transaction model
// Revision: 1.0
// ============================================================================
module tb_audio_capture_writer;

  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [1:0]    chan  = 2'd0;
  logic [31:0]   data  = 32'd0;
  logic          start0 = 1'b0, start1 = 1'b0, stop = 1'b0;
  logic [AW:0]   cw = '0;
  bit            sel = 1'b0;

  logic [AW-1:0] addr0, addr1;
  logic [7:0]    be0, be1;
  logic          cs0, cs1, wr0, wr1, ck0, ck1;
  logic [63:0]   wd0, wd1;
  logic          busy0, busy1, done0, done1, wrap0, wrap1, se0, se1;
  logic [AW:0]   ww0, ww1;

  audio_capture_writer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SAMPLE_WIDTH(32), .CIRCULAR(0)) u_oneshot (
    .clk(clk), .reset(reset), .avalon_sink_data(data), .avalon_sink_channel(chan),
    .avalon_sink_valid(valid), .start(start0), .stop(stop), .capture_words(cw),
    .address(addr0), .byteenable(be0), .chipselect(cs0), .write(wr0), .writedata(wd0),
    .clken(ck0), .busy(busy0), .done(done0), .wrapped(wrap0), .sync_err(se0),
    .words_written(ww0));

  audio_capture_writer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SAMPLE_WIDTH(32), .CIRCULAR(1)) u_circ (
    .clk(clk), .reset(reset), .avalon_sink_data(data), .avalon_sink_channel(chan),
    .avalon_sink_valid(valid), .start(start1), .stop(stop), .capture_words(cw),
    .address(addr1), .byteenable(be1), .chipselect(cs1), .write(wr1), .writedata(wd1),
    .clken(ck1), .busy(busy1), .done(done1), .wrapped(wrap1), .sync_err(se1),
    .words_written(ww1));

  wire [AW-1:0] o_addr = sel ? addr1 : addr0;
  wire [7:0]    o_be   = sel ? be1 : be0;
  wire          o_cs   = sel ? cs1 : cs0;
  wire          o_wr   = sel ? wr1 : wr0;
  wire [63:0]   o_wd   = sel ? wd1 : wd0;
  wire          o_ck   = sel ? ck1 : ck0;
  wire          o_busy = sel ? busy1 : busy0;
  wire          o_done = sel ? done1 : done0;
  wire          o_wrap = sel ? wrap1 : wrap0;
  wire          o_se   = sel ? se1 : se0;
  wire [AW:0]   o_ww   = sel ? ww1 : ww0;

  int nvec = 0;
  int nerr = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    int          addr;
    logic [63:0] data;
  } exp_wr_t;
  exp_wr_t exp_q[$];

  // Transaction-level model of the capture
  bit          m_busy, m_seen_left, m_held, m_done, m_wrapped, m_sync;
  logic [31:0] m_left;
  int          m_ptr, m_count, m_target;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_seen_left = 0; m_held = 0; m_done = 0; m_wrapped = 0; m_sync = 0;
    m_left = '0; m_ptr = 0; m_count = 0; m_target = 0;
  endtask

  task automatic model_apply(input bit v, input logic [1:0] ch, input logic [31:0] d,
                             input bit st, input bit sp);
    exp_wr_t e;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_seen_left = 0; m_held = 0; m_ptr = 0; m_count = 0;
        m_done = 0; m_wrapped = 0; m_sync = 0;
        m_target = (cw == 0) ? DEPTH : int'(cw);
      end
      return;
    end
    if (v && ch == 2'd0) begin
      if (m_held) m_sync = 1;
      m_left = d; m_held = 1; m_seen_left = 1;
    end else if (v && ch == 2'd1 && m_seen_left) begin
      if (m_held) begin
        e.cyc = cyc; e.addr = m_ptr; e.data = {d, m_left};
        exp_q.push_back(e);
        m_held = 0;
        if (sel && m_ptr == DEPTH - 1) m_wrapped = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (!sel || m_count < DEPTH) m_count++;
        if (!sel && m_count == m_target) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_sync = 1;
      end
    end
    if (sp && m_busy) begin
      m_busy = 0; m_done = 1; m_held = 0;
    end
  endtask

  task automatic step(input bit v, input logic [1:0] ch, input logic [31:0] d,
                      input bit st = 1'b0, input bit sp = 1'b0, input bit rs = 1'b0);
    valid = v; chan = ch; data = d;
    start0 = st && !sel; start1 = st && sel; stop = sp; reset = rs;
    @(posedge clk);
    cyc++;
    if (rs) model_reset();
    else    model_apply(v, ch, d, st, sp);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic pair(input logic [31:0] l, input logic [31:0] r);
    step(1'b1, 2'd0, l);
    step(1'b1, 2'd1, r);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"},  o_busy, m_busy);
    chk({tag, "_done"},  o_done, m_done);
    chk({tag, "_sync"},  o_se, m_sync);
    chk({tag, "_wrap"},  o_wrap, m_wrapped);
    chk({tag, "_words"}, o_ww, m_count);
    chk({tag, "_ptr"},   o_addr, m_ptr);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_be"},   o_be, 8'hFF);
    chk({tag, "_cs"},   o_cs, 0);
    chk({tag, "_wr"},   o_wr, 0);
    chk({tag, "_wd"},   o_wd, 0);
    chk({tag, "_ck"},   o_ck, 1);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_wrap"}, o_wrap, 0);
    chk({tag, "_se"},   o_se, 0);
    chk({tag, "_ww"},   o_ww, 0);
  endtask

  // Write-port monitor: every cycle either the next expected write or silence
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_wr_t e;
        e = exp_q.pop_front();
        chk("write_strobe", o_wr, 1);
        chk("write_cs", o_cs, 1);
        chk("write_addr", o_addr, e.addr);
        chk("write_data", o_wd, e.data);
      end else begin
        chk("no_write", o_wr, 0);
      end
    end
  end

  initial begin
    model_reset();
    step(1'b0, 2'd0, 32'd0, 0, 0, 1);
    step(1'b0, 2'd0, 32'd0, 0, 0, 1);
    mon_en = 1'b1;
    check_reset_values("reset");
    idle(1);

    // One-shot 4-word capture
    cw = 4;
    step(1'b0, 2'd0, 32'd0, 1);
    for (int i = 1; i <= 4; i++) pair(32'(i), 32'h8000_0000 + 32'(i));
    idle(3);
    check_status("oneshot4");
    chk("oneshot4_done_lit", o_done, 1);
    chk("oneshot4_words_lit", o_ww, 4);

    // Misaligned start: leading right sample dropped silently
    cw = 1;
    step(1'b0, 2'd0, 32'd0, 1);
    step(1'b1, 2'd1, 32'h0000_AAAA);
    pair(32'h0000_1111, 32'h0000_2222);
    idle(3);
    check_status("misalign");
    chk("misalign_sync_lit", o_se, 0);

    // Pairing errors: double left, then orphan right
    cw = 4;
    step(1'b0, 2'd0, 32'd0, 1);
    step(1'b1, 2'd0, 32'd5);
    pair(32'd6, 32'd7);
    step(1'b1, 2'd1, 32'd9);
    step(1'b1, 2'd2, 32'd10);
    step(1'b1, 2'd3, 32'd11);
    idle(3);
    check_status("pairing");
    chk("pairing_sync_lit", o_se, 1);

    // stop together with a right sample
    cw = 8;
    step(1'b0, 2'd0, 32'd0, 1);
    step(1'b1, 2'd0, 32'h11);
    step(1'b1, 2'd1, 32'h22, 0, 1);
    chk("stop_race_busy", o_busy, 0);
    chk("stop_race_done", o_done, 1);
    idle(3);
    check_status("stop_race");

    // Reset in the cycle after a right sample, then together with one
    step(1'b0, 2'd0, 32'd0, 1);
    pair(32'h33, 32'h44);
    step(1'b0, 2'd0, 32'd0, 0, 0, 1);
    check_reset_values("reset_after_r");
    step(1'b0, 2'd0, 32'd0, 1);
    step(1'b1, 2'd0, 32'h55);
    step(1'b1, 2'd1, 32'h66, 0, 0, 1);
    check_reset_values("reset_with_r");
    idle(2);

    // Randomized one-shot captures
    for (int round = 0; round < 8; round++) begin
      logic [1:0] nxt;
      cw = (AW+1)'($urandom_range(1, 12));
      step(1'b0, 2'd0, 32'd0, 1);
      nxt = 2'd0;
      for (int k = 0; k < 60; k++) begin
        int unsigned r;
        logic [1:0] ch;
        r = $urandom_range(0, 99);
        ch = (r < 85) ? nxt : 2'($urandom_range(0, 3));
        if (r >= 95) step(1'b0, 2'd0, $urandom);
        else begin
          step(1'b1, ch, $urandom, 0, ($urandom_range(0, 99) < 2));
          if (ch == 2'd0) nxt = 2'd1;
          else if (ch == 2'd1) nxt = 2'd0;
        end
      end
      idle(3);
      check_status("random");
    end

    // capture_words = 0 runs a full DEPTH of words
    cw = 0;
    step(1'b0, 2'd0, 32'd0, 1);
    for (int i = 0; i < DEPTH; i++) pair($urandom, $urandom);
    idle(3);
    check_status("full_depth");
    chk("full_depth_words_lit", o_ww, DEPTH);
    chk("full_depth_done_lit", o_done, 1);

    // start while busy is ignored
    cw = 5;
    step(1'b0, 2'd0, 32'd0, 1);
    pair(32'hA, 32'hB);
    step(1'b1, 2'd0, 32'hC);
    step(1'b0, 2'd0, 32'd0, 1);
    idle(2);
    check_status("busy_start");
    chk("busy_start_ptr_lit", o_addr, 1);
    step(1'b0, 2'd0, 32'd0, 0, 1);
    idle(2);

    // Continuous capture across the wrap point
    step(1'b0, 2'd0, 32'd0, 0, 0, 1);
    sel = 1'b1;
    idle(1);
    step(1'b0, 2'd0, 32'd0, 1);
    for (int i = 0; i < DEPTH + 2; i++) pair(32'(i), ~32'(i));
    idle(2);
    chk("circ_busy_before_stop", o_busy, 1);
    step(1'b0, 2'd0, 32'd0, 0, 1);
    idle(3);
    check_status("circular");
    chk("circ_wrapped_lit", o_wrap, 1);
    chk("circ_words_lit", o_ww, DEPTH);
    chk("circ_ptr_lit", o_addr, 2);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_capture_writer.md
Name: audio_capture_writer

Overview:
- Avalon-MM write master that captures a stereo Avalon-ST audio stream into the 64-bit single-port on-chip memory of the audiomini system.
- Packs left/right 32-bit samples into one 64-bit word and writes a run of words for later HPS readback.
- Sits directly upstream of the on-chip memory's write port, downstream of the audio stream.
- The memory has no waitrequest; every write completes in one cycle.

Parameters:
- ADDR_WIDTH, 13, memory word-address width.
- DEPTH, 8192, memory depth in 64-bit words; equals 2**ADDR_WIDTH.
- SAMPLE_WIDTH, 32, audio sample width; 2*SAMPLE_WIDTH = 64 = memory word width.
- CIRCULAR, 0, 0 = one-shot capture of capture_words words; 1 = continuous wrap until stop.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avalon_sink_data  in  32  audio sample, two's complement.
- avalon_sink_channel  in  2  0 = left, 1 = right, 2/3 ignored.
- avalon_sink_valid  in  1  sample valid; sink never backpressures.
- start  in  1  one-cycle pulse; arms a capture.
- stop  in  1  one-cycle pulse; aborts or ends a capture.
- capture_words  in  ADDR_WIDTH+1  words per one-shot capture, sampled on start; 0 means DEPTH.
- address  out  ADDR_WIDTH  memory word address.
- byteenable  out  8  memory byte enables.
- chipselect  out  1  memory select.
- write  out  1  memory write strobe.
- writedata  out  64  memory write data; [31:0] = left, [63:32] = right.
- clken  out  1  memory clock enable.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  sticky; set on capture end, cleared by start.
- wrapped  out  1  sticky; CIRCULAR mode pointer wrapped at least once.
- sync_err  out  1  sticky; L/R pairing violation; cleared by start.
- words_written  out  ADDR_WIDTH+1  count of words written in the current capture.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0, except clken = 1 and byteenable = 8'hFF (constants).
  - Holding register is cleared and the pointer is set to 0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE + start:
  - Enter ARMED.
  - Pointer <= 0, words_written <= 0.
  - done, wrapped and sync_err are cleared.
  - Target length latched; 0 maps to DEPTH.
- ARMED:
  - Wait for valid with channel 0.
  - Latch that sample into the left holding register, set held = 1, enter CAPTURE.
  - Right samples arriving before the first left are dropped silently; this is not an error.
- CAPTURE, valid channel 0:
  - If held = 0: latch the sample, held = 1.
  - If held = 1: replace the held sample and set sync_err.
- CAPTURE, valid channel 1:
  - If held = 1: register a write. In the next cycle write = chipselect = 1, address = pointer, writedata = {right, left}. Clear held.
  - If held = 0: drop the sample and set sync_err.
- Latency: the write strobe is high for exactly 1 cycle, beginning the cycle after the right sample's valid cycle.
- Write side effects:
  - Pointer increments and words_written increments, both in the write cycle.
  - Pointer wraps DEPTH-1 -> 0; in CIRCULAR mode a wrap sets wrapped.
- One-shot end: when words_written reaches the target, enter DONE the cycle after the last write and set done. Further samples are ignored.
- CIRCULAR = 1: the length is ignored; only stop ends the capture. words_written saturates at DEPTH.
- stop in ARMED or CAPTURE:
  - Enter DONE and set done.
  - A write already registered still issues.
  - A held unpaired left sample is discarded.
- Simultaneous events:
  - start in IDLE/DONE wins over stop.
  - start while busy is ignored.
  - stop together with a right sample: the pair is still written, then DONE.
- Channels 2 and 3 are ignored in every state.
- Reset mid-capture: the pending write is cancelled (write = 0 in the next cycle) and memory contents are untouched.
- Back-to-back L,R,L,R on consecutive cycles sustains 1 write per 2 cycles.

Decomposition:
- Package audio_capture_pkg holds:
  - capture_state_t enum (IDLE, ARMED, CAPTURE, DONE);
  - constants for channel codes (CH_LEFT = 0, CH_RIGHT = 1);
  - BYTEENABLE_ALL = 8'hFF.
- One sub-module: stereo_word_packer.
  - Holds the left register and held flag, and detects sync errors.
  - Emits pair_valid plus the 64-bit word.
  - The FSM/pointer logic stays in the top module.

Test Plan:
- One-shot 4-word capture:
  - Stimulus: capture_words = 4, start, then L/R pairs L = 0x00000001..4, R = 0x80000001..4.
  - Response: 4 writes at addresses 0..3 with writedata 0x80000001_00000001 etc., each 1 cycle after its R. done = 1, words_written = 4, sync_err = 0.
- Misaligned start:
  - Stimulus: start, then R = 0xAAAA, L = 0x1111, R = 0x2222.
  - Response: first R dropped, single write 0x00002222_00001111 at address 0, sync_err = 0.
- Pairing error:
  - Stimulus: while capturing, L = 5, L = 6, R = 7.
  - Response: sync_err = 1 and writedata = 0x00000007_00000006.
  - Stimulus: R without a held L.
  - Response: no write, sync_err stays 1.
- CIRCULAR = 1 wrap:
  - Stimulus: DEPTH + 2 pairs, then stop.
  - Response: addresses run 8191 -> 0 -> 1, wrapped = 1, words_written = 8192, done after stop.
- stop and reset races:
  - Stimulus: stop in the same cycle as an R.
  - Response: that pair is written and DONE is entered next cycle.
  - Stimulus: reset in the cycle after an R.
  - Response: write = 0, and all outputs are at reset values next cycle.
- capture_words = 0:
  - Stimulus: start with capture_words = 0.
  - Response: runs DEPTH words, then done.
  - Stimulus: start while busy.
  - Response: ignored; pointer unchanged.
